// File: rtl/fifo_reader.sv
// fifo_reader: consumer side of the FIFO rx_rdy/rx_done handshake.
// Strobes each drained word downstream and keeps count, checksum, timeout flag.
module fifo_reader #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 8,
   parameter int GAP     = 0,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic             rx_rdy,
   input  logic [WIDTH-1:0] out_data,
   output logic             rx_done,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [CNT_W-1:0] word_count,
   output logic [WIDTH-1:0] checksum,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_ACK,
      S_GAP
   } state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   // After a handshake ends (done or timed out) we either rest or go idle
   localparam state_t S_AFTER    = (GAP > 0) ? S_GAP : S_WAIT;
   localparam logic   AFTER_BUSY = (GAP > 0);

   state_t        state;
   logic [TW-1:0] to_cnt;
   logic [GW-1:0] gap_cnt;

   // Handshake FSM with all outputs registered; clear overrides stat updates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_WAIT;
         to_cnt     <= '0;
         gap_cnt    <= '0;
         rx_done    <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         word_count <= '0;
         checksum   <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         unique case (state)
            S_WAIT: begin
               if (en && rx_rdy) begin
                  rd_data <= out_data;
                  to_cnt  <= '0;
                  rx_done <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_ACK;
               end
            end
            S_ACK: begin
               if (!rx_rdy) begin
                  rx_done    <= 1'b0;
                  rd_valid   <= 1'b1;
                  word_count <= word_count + 1'b1;
                  checksum   <= checksum + rd_data;
                  gap_cnt    <= '0;
                  busy       <= AFTER_BUSY;
                  state      <= S_AFTER;
               end else if (to_cnt == TO_LAST) begin
                  err     <= 1'b1;
                  rx_done <= 1'b0;
                  gap_cnt <= '0;
                  busy    <= AFTER_BUSY;
                  state   <= S_AFTER;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= S_WAIT;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               rx_done <= 1'b0;
               busy    <= 1'b0;
               state   <= S_WAIT;
            end
         endcase
         if (clear) begin
            word_count <= '0;
            checksum   <= '0;
            err        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and random drains of a modelled FIFO.
// Outputs are compared against a queue-based word/count/checksum model.
module tb_fifo_reader;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 8;
   localparam int GAP     = 3;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             clear;
   logic             rx_rdy;
   logic [WIDTH-1:0] out_data;
   logic             rx_done;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [CNT_W-1:0] word_count;
   logic [WIDTH-1:0] checksum;
   logic             busy;
   logic             err;

   always #5 clk = ~clk;

   fifo_reader #(
      .WIDTH  (WIDTH),
      .CNT_W  (CNT_W),
      .GAP    (GAP),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clear     (clear),
      .rx_rdy    (rx_rdy),
      .out_data  (out_data),
      .rx_done   (rx_done),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .word_count(word_count),
      .checksum  (checksum),
      .busy      (busy),
      .err       (err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] fq[$];
   logic [7:0] expw[$];
   logic [7:0] got[$];
   logic [7:0] pend[$];
   int  mcount = 0;
   int  msum = 0;
   bit  stuck = 1'b0;
   bit  rand_en = 1'b0;

   int   cyc = 0;
   int   nvalid = 0;
   int   hi_run = 0;
   int   last_run = 0;
   int   fall_cyc = -1;
   int   last_gap = 0;
   int   rise_viol = 0;
   int   dbl_valid = 0;
   logic prev_done = 1'b0;
   logic prev_valid = 1'b0;

   // Monitor: sampled just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rd_valid === 1'b1) begin
            nvalid++;
            got.push_back(rd_data);
            if (prev_valid === 1'b1) dbl_valid++;
         end
         if (rx_done === 1'b1) begin
            if (prev_done !== 1'b1) begin
               hi_run = 1;
               if (rx_rdy !== 1'b1) rise_viol++;
               if (fall_cyc >= 0) last_gap = cyc - fall_cyc;
            end else begin
               hi_run++;
            end
         end else if (prev_done === 1'b1) begin
            last_run = hi_run;
            fall_cyc = cyc;
         end
         prev_done  = rx_done;
         prev_valid = rd_valid;
      end
   end

   // Behavioural FIFO: four-phase responder, garbage on out_data when idle
   initial begin
      rx_rdy   = 1'b0;
      out_data = '0;
      forever begin
         @(negedge clk);
         if (rx_done && rx_rdy && !stuck) begin
            void'(fq.pop_front());
            rx_rdy   = 1'b0;
            out_data = 8'($urandom);
         end else if (!rx_done && !rx_rdy && fq.size() > 0) begin
            rx_rdy   = 1'b1;
            out_data = fq[0];
         end
         if (rand_en) en = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(logic [7:0] w);
      fq.push_back(w);
      expw.push_back(w);
      pend.push_back(w);
   endtask

   task automatic drain(int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         tick();
         if (fq.size() == 0 && !rx_rdy && !busy && !rx_done) break;
      end
      chk("drain_bound", 32'(i < budget), 32'd1);
      while (pend.size() > 0) begin
         mcount++;
         msum += int'(pend.pop_front());
      end
   endtask

   task automatic wait_done_hi(string tag);
      int i;
      for (i = 0; i < 50; i++) begin
         tick();
         if (rx_done) break;
      end
      chk(tag, 32'(rx_done), 32'd1);
   endtask

   task automatic chk_model(string tag);
      chk({tag, "_count"}, 32'(word_count), 32'(mcount % (1 << CNT_W)));
      chk({tag, "_sum"}, 32'(checksum), 32'(msum % (1 << WIDTH)));
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_rx_done"}, 32'(rx_done), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      chk({tag, "_count"}, 32'(word_count), 32'd0);
      chk({tag, "_sum"}, 32'(checksum), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int nv0;
      rst_n = 1'b0;
      en    = 1'b0;
      clear = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_vals("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // single word
      push(8'h5A);
      en = 1'b1;
      drain(60);
      chk_model("single");
      chk("single_err", 32'(err), 32'd0);
      chk("single_hi_run", 32'(last_run), 32'd1);
      chk("single_strobes", 32'(nvalid), 32'd1);

      // five-word drain
      push(8'h24);
      push(8'h81);
      push(8'h09);
      push(8'h63);
      push(8'h0D);
      drain(100);
      chk_model("five");
      chk("five_strobes", 32'(nvalid), 32'd6);

      // gap between consecutive reads
      push(8'hC3);
      push(8'h3C);
      drain(60);
      chk_model("gap");
      chk("gap_len", 32'(last_gap), 32'(GAP + 1));

      // stuck FIFO: timeout
      en = 1'b0;
      stuck = 1'b1;
      push(8'h33);
      repeat (3) tick();
      nv0 = nvalid;
      en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (err) break;
      end
      en = 1'b0;
      chk("to_err", 32'(err), 32'd1);
      chk("to_hi_run", 32'(last_run), 32'(TIMEOUT));
      chk("to_rx_done", 32'(rx_done), 32'd0);
      chk("to_no_strobe", 32'(nvalid), 32'(nv0));
      chk_model("to");
      repeat (5) tick();
      chk("to_err_sticky", 32'(err), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mcount = 0;
      msum = 0;
      chk("clr_err", 32'(err), 32'd0);
      chk_model("clr");
      stuck = 1'b0;
      en = 1'b1;
      drain(60);
      chk_model("retry");

      // en dropped right after acceptance
      nv0 = nvalid;
      push(8'hA5);
      wait_done_hi("en_drop_start");
      en = 1'b0;
      push(8'h11);
      push(8'h22);
      repeat (12) tick();
      chk("en_drop_strobes", 32'(nvalid), 32'(nv0 + 1));
      chk("en_drop_idle", 32'(busy), 32'd0);
      chk("en_drop_no_done", 32'(rx_done), 32'd0);
      en = 1'b1;
      drain(80);
      chk_model("en_drop");

      // clear on the completion edge
      en = 1'b0;
      push(8'h77);
      repeat (3) tick();
      en = 1'b1;
      wait_done_hi("clr_comp_start");
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_comp_valid", 32'(rd_valid), 32'd1);
      chk("clr_comp_data", 32'(rd_data), 32'h77);
      chk("clr_comp_count", 32'(word_count), 32'd0);
      chk("clr_comp_sum", 32'(checksum), 32'd0);
      pend.delete();
      mcount = 0;
      msum = 0;
      drain(40);
      chk_model("clr_comp");

      // async reset while in ACK
      en = 1'b0;
      stuck = 1'b1;
      push(8'h99);
      repeat (3) tick();
      en = 1'b1;
      wait_done_hi("rst_ack_start");
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_ack");
      mcount = 0;
      msum = 0;
      stuck = 1'b0;
      en = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      en = 1'b1;
      drain(60);
      chk_model("rst_ack");

      // random burst, wraps word_count
      for (int i = 0; i < 300; i++) push(8'($urandom));
      rand_en = 1'b1;
      drain(9000);
      rand_en = 1'b0;
      en = 1'b1;
      chk_model("rand");
      chk("rand_err", 32'(err), 32'd0);

      // stream-level properties
      chk("n_words", 32'(got.size()), 32'(expw.size()));
      for (int i = 0; i < got.size() && i < expw.size(); i++)
         chk("word_seq", 32'(got[i]), 32'(expw[i]));
      chk("rise_without_rdy", 32'(rise_viol), 32'd0);
      chk("double_strobe", 32'(dbl_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side controller for the FIFO receive interface. It drains words one at a time using the four-phase rx_rdy/rx_done handshake, presents each word downstream with a one-cycle valid strobe, and keeps a running word count and modular checksum. It sits between the FIFO's `rx_rdy`/`rx_done`/`out_data` port and downstream logic. It also contains a programmable inter-read gap and a handshake timeout watchdog.

## Interface
- `WIDTH`, 8: data word width; must match the FIFO.
- `CNT_W`, 8: width of the word counter.
- `GAP`, 0: idle cycles inserted after each completed read before the next may start.
- `TIMEOUT`, 16: maximum cycles rx_done may be held waiting for rx_rdy to fall; must be ≥1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  permits starting a new read; sampled only in WAIT.
- `clear`  in  1  synchronous clear of `word_count`, `checksum`, `err`.
- `rx_rdy`  in  1  from FIFO: a word is available on `out_data`.
- `out_data`  in  WIDTH  from FIFO: head-of-queue word.
- `rx_done`  out  1  to FIFO: word taken; held until `rx_rdy` falls.
- `rd_data`  out  WIDTH  last captured word.
- `rd_valid`  out  1  one-cycle strobe: `rd_data` is a newly completed word.
- `word_count`  out  CNT_W  completed reads, modulo 2^CNT_W.
- `checksum`  out  WIDTH  sum of completed words, modulo 2^WIDTH.
- `busy`  out  1  high in any state other than WAIT.
- `err`  out  1  sticky handshake-timeout flag.

## Operation
- Reset (async, `rst_n`=0): state WAIT.
  - `rx_done`=0, `rd_valid`=0, `rd_data`=0, `word_count`=0, `checksum`=0, `err`=0, `busy`=0.
  - Gap and timeout counters are cleared.
  - Reset mid-handshake drops `rx_done` immediately. The word in flight is neither counted nor strobed.
- FSM states: WAIT, ACK, GAP.
  - WAIT: `rx_done`=0. If `en`=1 and `rx_rdy`=1 at the edge: `rd_data`<=`out_data`, timeout counter <=0, go to ACK.
  - ACK: `rx_done`=1.
    - If `rx_rdy`=0 at the edge, the handshake completes:
      - `rx_done`<=0 and `rd_valid`<=1 for one cycle.
      - `word_count`<=+1 and `checksum`<=`checksum`+`rd_data`.
      - Next state is GAP if `GAP`>0, else WAIT.
    - Else, if the timeout counter equals `TIMEOUT`-1:
      - `err`<=1 and `rx_done`<=0.
      - No strobe and no count update.
      - Next state is GAP if `GAP`>0, else WAIT.
    - Else the timeout counter increments.
  - GAP: `rx_done`=0. Stays exactly `GAP` cycles, then goes to WAIT.
- `en` low never aborts a handshake in progress. It only blocks leaving WAIT.
- `clear` has priority over same-cycle updates. If `clear` coincides with completion, `word_count`=0 and `checksum`=0 after the edge. `rd_valid` still pulses and `rd_data` is unaffected.
- Wrap-around:
  - `word_count` goes from 2^CNT_W-1 to 0.
  - `checksum` keeps only the low WIDTH bits.
- `err` stays 1 until `clear` or reset. It does not block further reads.

## Timing
- Edge E0 (WAIT, `en`=1, `rx_rdy`=1): `rd_data` is valid after E0, and `rx_done` is high after E0.
- First edge E1 with `rx_rdy`=0 while in ACK: after E1, `rx_done`=0 and `rd_valid`=1. `word_count` and `checksum` are updated after E1.
- `rd_valid` is high for exactly one cycle per completed word.
- With `GAP`=0, a new read can be accepted at E1+1 if `rx_rdy` is high.
  - The minimum period is therefore 2 cycles per word plus the FIFO's `rx_rdy` fall latency.
- With `GAP`=g, WAIT is re-entered g cycles after E1.
- Timeout: if `rx_rdy` stays high, `rx_done` is high for exactly `TIMEOUT` cycles, then drops and `err` rises on the same edge.
- `out_data` is sampled only at E0. Later changes on `out_data` do not affect `rd_data`.

## Test plan
- Single word, `GAP`=0:
  - Stimulus: FIFO holds 0x5A, `en`=1.
  - Response: `rx_done` high for at least 1 cycle. `rd_valid` pulses once with `rd_data`=0x5A. `word_count`=1, `checksum`=0x5A, `err`=0.
- Five-word drain:
  - Stimulus: FIFO is full with 0x24, 0x81, 0x09, 0x63, 0x0D.
  - Response: five `rd_valid` pulses in that order. `word_count`=5, `checksum`=0x1E (0x11E truncated to 8 bits). `rx_done` never high while FIFO is empty.
- Gap enforcement, `GAP`=3:
  - Stimulus: FIFO holds two words.
  - Response: exactly 3 cycles in GAP between the fall of `rx_done` and the next WAIT acceptance.
- Stuck FIFO, `TIMEOUT`=16:
  - Stimulus: hold `rx_rdy`=1 with no dequeue.
  - Response: `rx_done` high for 16 cycles. `err`=1, no `rd_valid`, `word_count` unchanged. Then `clear` -> `err`=0.
- Control corners:
  - `en` dropped one cycle after E0 -> handshake still completes and `word_count` increments. No new read starts while `en`=0.
  - `clear` on the completion edge -> `word_count`=0, `checksum`=0, and `rd_valid` still pulses.
- Async reset mid-ACK:
  - Stimulus: `rst_n` low while in ACK.
  - Response: `rx_done` falls without waiting for a clock, and all outputs return to reset values. `CNT_W`=2 run of 5 words -> `word_count` goes 1,2,3,0,1.
